ether_tx_arb: RTL and testbench

Round-robin transmit scheduler that shares one Ethernet frame serializer between two frame requesters. On grant it captures the requester's DA/SA/LEN/DATA/CRC fields and prepends the fixed preamble and SFD to form the 576-bit frame. It then streams the frame out MSB-first, one byte per accepted cycle with backpressure, and enforces an inter-frame gap. It sits between the frame-building logic and the byte-wide MAC/PHY transmit path.

---
 rtl/ether_tx_arb.sv | 172 +++++++++++++++++
 tb/tb_ether_tx_arb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_tx_arb.sv
// Round-robin scheduler sharing one byte-wide Ethernet frame serializer between two requesters.
// Optional feature: define ETH_TX_STATS_EN to add per-requester 16-bit sent-frame counters.
module ether_tx_arb #(
   parameter int IFG = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [47:0]  da0,
   input  logic [47:0]  sa0,
   input  logic [47:0]  da1,
   input  logic [47:0]  sa1,
   input  logic [15:0]  len0,
   input  logic [15:0]  len1,
   input  logic [367:0] data0,
   input  logic [367:0] data1,
   input  logic [31:0]  crc0,
   input  logic [31:0]  crc1,
   output logic         grant0,
   output logic         grant1,
   output logic [7:0]   tx_byte,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         tx_sof,
   output logic         tx_eof,
   output logic         busy
`ifdef ETH_TX_STATS_EN
  ,output logic [15:0]  frm_cnt0,
   output logic [15:0]  frm_cnt1
`endif
);

   localparam logic [63:0] PREAMBLE_SFD = {56'hAAAA_AAAA_AAAA_AA, 8'hAB};
   localparam logic [6:0]  LAST_BYTE    = 7'd71;
   localparam logic [6:0]  PENULT_BYTE  = 7'd70;
   localparam logic [7:0]  GAP_LAST     = (IFG > 0) ? 8'(IFG - 1) : 8'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
   } state_e;

   state_e         state_q;
   logic [575:0]   sreg_q;
   logic [6:0]     byte_cnt_q;
   logic [7:0]     gap_cnt_q;
   logic           last_grant_q;
   logic           grant0_q;
   logic           grant1_q;
   logic           tx_valid_q;
   logic           tx_sof_q;
   logic           tx_eof_q;

   logic           pick1_d;
   logic [575:0]   frame_d;
   logic           accept;

   // Tie goes to whichever requester was not served last.
   always_comb begin
      // NOTE: every always_comb output is defaulted first so no path can infer a latch.
      pick1_d = 1'b0;
      frame_d = {PREAMBLE_SFD, da0, sa0, len0, data0, crc0};
      if (req1 && (!req0 || !last_grant_q)) begin
         pick1_d = 1'b1;
         frame_d = {PREAMBLE_SFD, da1, sa1, len1, data1, crc1};
      end
   end

   assign accept = tx_valid_q && tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         // NOTE: the frame register is reset too, so an aborted frame never leaks onto tx_byte.
         sreg_q       <= '0;
         byte_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         last_grant_q <= 1'b1;
         grant0_q     <= 1'b0;
         grant1_q     <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_sof_q     <= 1'b0;
         tx_eof_q     <= 1'b0;
      end else begin
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req0 || req1) begin
                  grant0_q     <= !pick1_d;
                  grant1_q     <= pick1_d;
                  last_grant_q <= pick1_d;
                  sreg_q       <= frame_d;
                  byte_cnt_q   <= '0;
                  tx_valid_q   <= 1'b1;
                  tx_sof_q     <= 1'b1;
                  tx_eof_q     <= 1'b0;
                  state_q      <= S_SEND;
               end
            end
            S_SEND: begin
               if (accept) begin
                  sreg_q   <= {sreg_q[567:0], 8'h00};
                  tx_sof_q <= 1'b0;
                  if (byte_cnt_q == LAST_BYTE) begin
                     tx_valid_q <= 1'b0;
                     tx_eof_q   <= 1'b0;
                     byte_cnt_q <= '0;
                     gap_cnt_q  <= '0;
                     state_q    <= (IFG > 0) ? S_GAP : S_IDLE;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 7'd1;
                     tx_eof_q   <= (byte_cnt_q == PENULT_BYTE);
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant0   = grant0_q;
   assign grant1   = grant1_q;
   assign tx_valid = tx_valid_q;
   assign tx_sof   = tx_sof_q;
   assign tx_eof   = tx_eof_q;
   assign tx_byte  = tx_valid_q ? sreg_q[575:568] : 8'h00;
   assign busy     = (state_q == S_SEND) || (state_q == S_GAP);

`ifdef ETH_TX_STATS_EN
   logic [15:0] frm_cnt0_q;
   logic [15:0] frm_cnt0_d;
   logic [15:0] frm_cnt1_q;
   logic [15:0] frm_cnt1_d;

   // last_grant_q names the owner of the frame currently in flight.
   always_comb begin
      frm_cnt0_d = frm_cnt0_q;
      frm_cnt1_d = frm_cnt1_q;
      if (accept && tx_eof_q) begin
         if (last_grant_q) begin
            frm_cnt1_d = frm_cnt1_q + 16'd1;
         end else begin
            frm_cnt0_d = frm_cnt0_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frm_cnt0_q <= '0;
         frm_cnt1_q <= '0;
      end else begin
         frm_cnt0_q <= frm_cnt0_d;
         frm_cnt1_q <= frm_cnt1_d;
      end
   end

   assign frm_cnt0 = frm_cnt0_q;
   assign frm_cnt1 = frm_cnt1_q;
`endif

endmodule

// File: tb/tb_ether_tx_arb.sv
// Directed-sequence bench for ether_tx_arb with randomized frame fields and a frame-level reference model.
// Instance dut uses IFG=12; instance dut_z uses IFG=0 for the back-to-back case.
module tb_ether_tx_arb;

   localparam int IFG_A = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         req0, req1;
   logic [47:0]  da0, sa0, da1, sa1;
   logic [15:0]  len0, len1;
   logic [367:0] data0, data1;
   logic [31:0]  crc0, crc1;
   logic         grant0, grant1;
   logic [7:0]   tx_byte;
   logic         tx_valid, tx_ready, tx_sof, tx_eof, busy;

   logic         z_req0, z_req1, z_ready;
   logic         z_grant0, z_grant1;
   logic [7:0]   z_byte;
   logic         z_valid, z_sof, z_eof, z_busy;

`ifdef ETH_TX_STATS_EN
   logic [15:0]  frm_cnt0, frm_cnt1, z_cnt0, z_cnt1;
`endif

   ether_tx_arb #(.IFG(IFG_A)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .da0(da0), .sa0(sa0), .da1(da1), .sa1(sa1),
      .len0(len0), .len1(len1), .data0(data0), .data1(data1),
      .crc0(crc0), .crc1(crc1), .grant0(grant0), .grant1(grant1),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy)
`ifdef ETH_TX_STATS_EN
     ,.frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1)
`endif
   );

   ether_tx_arb #(.IFG(0)) dut_z (
      .clk(clk), .rst(rst), .req0(z_req0), .req1(z_req1),
      .da0(da0), .sa0(sa0), .da1(da1), .sa1(sa1),
      .len0(len0), .len1(len1), .data0(data0), .data1(data1),
      .crc0(crc0), .crc1(crc1), .grant0(z_grant0), .grant1(z_grant1),
      .tx_byte(z_byte), .tx_valid(z_valid), .tx_ready(z_ready),
      .tx_sof(z_sof), .tx_eof(z_eof), .busy(z_busy)
`ifdef ETH_TX_STATS_EN
     ,.frm_cnt0(z_cnt0), .frm_cnt1(z_cnt1)
`endif
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          m_last;
   logic [15:0] m_cnt0, m_cnt1;
   logic [7:0]  got [72];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic rand_fields(input bit n);
      logic [383:0] d;
      logic [63:0]  r;
      for (int i = 0; i < 12; i++) d[i*32 +: 32] = $urandom;
      if (n) begin
         r = {$urandom, $urandom}; da1 = r[47:0];
         r = {$urandom, $urandom}; sa1 = r[47:0];
         len1 = 16'($urandom); data1 = d[367:0]; crc1 = $urandom;
      end else begin
         r = {$urandom, $urandom}; da0 = r[47:0];
         r = {$urandom, $urandom}; sa0 = r[47:0];
         len0 = 16'($urandom); data0 = d[367:0]; crc0 = $urandom;
      end
   endtask

   // Expected 576-bit frame: preamble, SFD, then the requester's fields in wire order.
   function automatic logic [575:0] frame_of(input bit n);
      if (n) return {56'hAAAA_AAAA_AAAA_AA, 8'hAB, da1, sa1, len1, data1, crc1};
      return {56'hAAAA_AAAA_AAAA_AA, 8'hAB, da0, sa0, len0, data0, crc0};
   endfunction

   // Lone requester wins; on a tie the one not served last wins.
   function automatic bit model_pick(input bit r0, input bit r1, input bit last);
      if (r0 && r1) return !last;
      return r1;
   endfunction

   // Waits for a grant, then checks every byte of the frame; toggle alternates tx_ready 1,0,...
   task automatic run_frame(input bit toggle, input bit drop_req,
                            output bit who, output int g_cyc, output int e_cyc, output int n_send);
      logic [575:0] exp;
      int idx;
      int n;
      tx_ready = 1'b1;
      n = 0;
      while (!(grant0 || grant1) && n < 400) begin
         tick();
         n++;
      end
      check("grant_seen", 64'(grant0 || grant1), 64'd1);
      who = 1'b0; g_cyc = cyc; e_cyc = cyc; n_send = 0;
      if (!(grant0 || grant1)) return;
      who = model_pick(req0, req1, m_last);
      check("grant0", 64'(grant0), 64'(!who));
      check("grant1", 64'(grant1), 64'(who));
      m_last = who;
      exp = frame_of(who);
      if (drop_req) begin
         if (who) req1 = 1'b0; else req0 = 1'b0;
      end
      rand_fields(who);
      idx = 0;
      n = 0;
      while (idx < 72 && n < 400) begin
         if (toggle && n > 0) tx_ready = ~tx_ready;
         check("grant_pulse", 64'(grant0 || grant1), 64'(n == 0));
         check("tx_valid", 64'(tx_valid), 64'd1);
         check("tx_byte", 64'(tx_byte), 64'(exp[575 - 8*idx -: 8]));
         check("tx_sof", 64'(tx_sof), 64'(idx == 0));
         check("tx_eof", 64'(tx_eof), 64'(idx == 71));
         check("busy_send", 64'(busy), 64'd1);
         if (tx_ready) begin
            got[idx] = tx_byte;
            idx++;
         end
         if (idx == 72) break;
         tick();
         n++;
      end
      check("frame_len", 64'(idx), 64'd72);
      e_cyc = cyc;
      n_send = n + 1;
      if (who) m_cnt1 = m_cnt1 + 16'd1; else m_cnt0 = m_cnt0 + 16'd1;
      tx_ready = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit           who, prev_who;
      int           g, e, ns, prev_e, start, n, zi, zf, eof1, sof2;
      logic [575:0] zexp, rexp;

      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; tx_ready = 1'b0;
      z_req0 = 1'b0; z_req1 = 1'b0; z_ready = 1'b1;
      rand_fields(1'b0); rand_fields(1'b1);
      m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
      tick(); tick();

      // Reset state
      check("rst_grant0", 64'(grant0), 64'd0);
      check("rst_grant1", 64'(grant1), 64'd0);
      check("rst_valid", 64'(tx_valid), 64'd0);
      check("rst_sof", 64'(tx_sof), 64'd0);
      check("rst_eof", 64'(tx_eof), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_byte", 64'(tx_byte), 64'd0);
`ifdef ETH_TX_STATS_EN
      check("rst_cnt0", 64'(frm_cnt0), 64'd0);
      check("rst_cnt1", 64'(frm_cnt1), 64'd0);
`endif
      rst = 1'b0;
      tick();
      check("idle_valid", 64'(tx_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      // Single frame from req0 with a known DA, then the full inter-frame gap
      da0 = 48'h0011_2233_4455;
      req0 = 1'b1;
      start = cyc;
      run_frame(1'b0, 1'b1, who, g, e, ns);
      check("single_who", 64'(who), 64'd0);
      check("single_grant_lat", 64'(g - start), 64'd1);
      check("single_eof_lat", 64'(e - start), 64'd72);
      check("single_send_cycles", 64'(ns), 64'd72);
      check("byte0", 64'(got[0]), 64'hAA);
      check("byte6", 64'(got[6]), 64'hAA);
      check("byte7_sfd", 64'(got[7]), 64'hAB);
      check("byte8_da", 64'(got[8]), 64'h00);
      check("byte9_da", 64'(got[9]), 64'h11);
      check("byte13_da", 64'(got[13]), 64'h55);
      for (int i = 0; i < IFG_A; i++) begin
         tx_ready = 1'($urandom);
         tick();
         check("gap_busy", 64'(busy), 64'd1);
         check("gap_valid", 64'(tx_valid), 64'd0);
         check("gap_byte", 64'(tx_byte), 64'd0);
      end
      tick();
      check("post_gap_busy", 64'(busy), 64'd0);
      check("post_gap_grant", 64'(grant0 || grant1), 64'd0);

      // Both requesters held: alternation and exact next-grant spacing
      req0 = 1'b1; req1 = 1'b1;
      prev_e = 0; prev_who = 1'b0;
      for (int f = 0; f < 4; f++) begin
         if (f == 3) begin
            run_frame(1'b0, 1'b0, who, g, e, ns);
            req0 = 1'b0; req1 = 1'b0;
         end else begin
            run_frame(1'b0, 1'b0, who, g, e, ns);
         end
         if (f > 0) begin
            check("tie_alternate", 64'(who), 64'(!prev_who));
            check("tie_spacing", 64'(g - prev_e), 64'(IFG_A + 2));
         end
         prev_who = who;
         prev_e = e;
      end

      // Backpressure: tx_ready alternates 1,0 during the frame
      req1 = 1'b1;
      run_frame(1'b1, 1'b1, who, g, e, ns);
      check("bp_who", 64'(who), 64'd1);
      check("bp_cycles", 64'(ns), 64'd143);

      // IFG=0 instance: two back-to-back frames from req1
      zexp = frame_of(1'b1);
      z_req1 = 1'b1;
      zi = 0; zf = 0; eof1 = -1; sof2 = -1; n = 0;
      while (zf < 2 && n < 400) begin
         tick();
         n++;
         if (z_valid) begin
            check("z_byte", 64'(z_byte), 64'(zexp[575 - 8*zi -: 8]));
            check("z_sof", 64'(z_sof), 64'(zi == 0));
            check("z_eof", 64'(z_eof), 64'(zi == 71));
            if (z_sof) check("z_grant1", 64'(z_grant1), 64'd1);
            if (z_sof && zf == 1) sof2 = cyc;
            zi++;
            if (zi == 72) begin
               zi = 0;
               zf++;
               if (zf == 1) eof1 = cyc;
            end
         end
      end
      z_req1 = 1'b0;
      check("z_frames", 64'(zf), 64'd2);
      check("z_ifg0_gap", 64'(sof2 - eof1), 64'd2);

      // Reset mid-frame on a req0 frame, then a tie must go to req0
      req0 = 1'b1;
      n = 0;
      while (!(grant0 || grant1) && n < 400) begin
         tick();
         n++;
      end
      check("abort_grant0", 64'(grant0), 64'd1);
      rexp = frame_of(1'b0);
      m_last = 1'b0;
      req0 = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      check("abort_byte30", 64'(tx_byte), 64'(rexp[575 - 240 -: 8]));
      rst = 1'b1;
      #1;
      check("abort_valid", 64'(tx_valid), 64'd0);
      check("abort_byte", 64'(tx_byte), 64'd0);
      check("abort_eof", 64'(tx_eof), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
`ifdef ETH_TX_STATS_EN
      check("abort_cnt0", 64'(frm_cnt0), 64'd0);
`endif
      req0 = 1'b1; req1 = 1'b1;
      tick();
      rst = 1'b0;
      run_frame(1'b0, 1'b0, who, g, e, ns);
      req0 = 1'b0; req1 = 1'b0;
      check("post_rst_who", 64'(who), 64'd0);

      // Three frames from req1, one from req0
      for (int f = 0; f < 3; f++) begin
         req1 = 1'b1;
         run_frame(1'b0, 1'b1, who, g, e, ns);
         check("stat_who1", 64'(who), 64'd1);
      end
      req0 = 1'b1;
      run_frame(1'b0, 1'b1, who, g, e, ns);
      check("stat_who0", 64'(who), 64'd0);
      tick();
`ifdef ETH_TX_STATS_EN
      check("cnt0", 64'(frm_cnt0), 64'(m_cnt0));
      check("cnt1", 64'(frm_cnt1), 64'(m_cnt1));
      force dut.frm_cnt0_q = 16'hFFFF;
      #1;
      release dut.frm_cnt0_q;
      m_cnt0 = 16'hFFFF;
      check("cnt0_preload", 64'(frm_cnt0), 64'hFFFF);
      req0 = 1'b1;
      run_frame(1'b0, 1'b1, who, g, e, ns);
      tick();
      check("cnt0_wrap_model", 64'(frm_cnt0), 64'(m_cnt0));
      check("cnt0_wrap", 64'(frm_cnt0), 64'd0);
      check("cnt1_hold", 64'(frm_cnt1), 64'(m_cnt1));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
